led_arbiter_ctrl: RTL and testbench

Priority arbiter and sequencer for the 4-LED status bank on the 50 MHz domain. Up to three status sources request the LEDs, each with a display mode and a 4-bit pattern. The block grants one source at a time, generates the shared step tick, and drives the active-low LED outputs. It sits between the measurement/fault status logic and the board LED pins.

---
 rtl/led_arbiter_ctrl.sv | 161 ++++++++++++++++
 tb/tb_led_arbiter_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/led_arbiter_ctrl.sv
// Purpose : priority arbiter and pattern sequencer for the 4-LED status bank.
// Latency : request/release to grant and led_out = 1 cycle; a pattern step shows the cycle after tick.
// Backpressure: none; each source holds its req for as long as it wants the LEDs.
//
// Ports:
//   clk_50M, rst_n        50 MHz clock, asynchronous active-low reset
//   req[2:0]              per-source request, req[2] has the highest priority
//   req_mode[5:0]         source i mode at [2i+1:2i]: 00 static, 01 blink, 10 rot left, 11 rot right
//   req_pat[11:0]         source i pattern at [4i+3:4i], 1 = LED lit
//   grant[2:0]            one-hot owner, 0 when idle
//   busy                  a grant is active
//   tick                  one-cycle step pulse, free running, shared with other blocks
//   led_out[3:0]          active-low LED drive
// Build option: define LED_ARB_PREEMPT_EN to let a higher-priority req take the LEDs on a
// tick once the current owner has held them for MIN_HOLD_TICKS ticks.
module led_arbiter_ctrl #(
    parameter logic [24:0] CNT_MAX_TICK   = 25'd24_999_999,
    parameter logic [3:0]  MIN_HOLD_TICKS = 4'd2
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [5:0]  req_mode,
    input  logic [11:0] req_pat,
    output logic [2:0]  grant,
    output logic        busy,
    output logic        tick,
    output logic [3:0]  led_out
);

`ifdef LED_ARB_PREEMPT_EN
    localparam bit PREEMPT_EN = 1'b1;
`else
    localparam bit PREEMPT_EN = 1'b0;
`endif

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [24:0] cnt;
    logic [1:0]  mode_q, mode_nxt;
    logic [3:0]  pat_q, pat_nxt;
    logic [3:0]  hold_cnt, hold_nxt;
    logic [2:0]  grant_nxt;
    logic [3:0]  led_nxt;

    logic [2:0]  win;
    logic [1:0]  win_mode;
    logic [3:0]  win_pat;
    logic        own_req;
    logic [2:0]  higher_mask;
    logic        preempt;
    logic        do_load;
    logic        do_step;

    // Free-running step tick, independent of the arbiter state.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_MAX_TICK) ? '0 : cnt + 25'd1;
            tick <= (cnt == CNT_MAX_TICK);
        end
    end

    // Highest asserted request and its mode/pattern.
    always_comb begin
        win      = 3'b000;
        win_mode = 2'b00;
        win_pat  = 4'b0000;
        if (req[2]) begin
            win = 3'b100; win_mode = req_mode[5:4]; win_pat = req_pat[11:8];
        end else if (req[1]) begin
            win = 3'b010; win_mode = req_mode[3:2]; win_pat = req_pat[7:4];
        end else if (req[0]) begin
            win = 3'b001; win_mode = req_mode[1:0]; win_pat = req_pat[3:0];
        end
    end

    assign own_req = |(req & grant);
    // Bits strictly above the one-hot owner: 001 -> 110, 010 -> 100, 100 -> 000.
    assign higher_mask = ~(grant | (grant - 3'd1));
    assign preempt = PREEMPT_EN && (|(req & higher_mask)) && (hold_cnt >= MIN_HOLD_TICKS);

    // State register plus the registered datapath it controls.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            grant    <= 3'b000;
            mode_q   <= 2'b00;
            pat_q    <= 4'b0000;
            hold_cnt <= 4'd0;
            led_out  <= 4'b1111;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            mode_q   <= mode_nxt;
            pat_q    <= pat_nxt;
            hold_cnt <= hold_nxt;
            led_out  <= led_nxt;
        end
    end

    // Next state. A dropped request takes precedence over a coincident tick,
    // so a preemption and a drop in the same cycle collapse into one load.
    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_step   = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_nxt = S_RUN;
                    do_load   = 1'b1;
                end
            end
            S_RUN: begin
                if (!own_req) begin
                    if (|req) do_load   = 1'b1;
                    else      state_nxt = S_IDLE;
                end else if (tick) begin
                    if (preempt) do_load = 1'b1;
                    else         do_step = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        grant_nxt = grant;
        mode_nxt  = mode_q;
        pat_nxt   = pat_q;
        hold_nxt  = hold_cnt;
        led_nxt   = led_out;
        if (state_nxt == S_IDLE) begin
            grant_nxt = 3'b000;
            hold_nxt  = 4'd0;
            led_nxt   = 4'b1111;
        end else if (do_load) begin
            grant_nxt = win;
            mode_nxt  = win_mode;
            pat_nxt   = win_pat;
            hold_nxt  = 4'd0;
            led_nxt   = ~win_pat;
        end else if (do_step) begin
            hold_nxt = (hold_cnt == 4'hF) ? hold_cnt : hold_cnt + 4'd1;
            case (mode_q)
                2'b00:   led_nxt = led_out;
                2'b01:   led_nxt = (led_out == ~pat_q) ? 4'b1111 : ~pat_q;
                2'b10:   led_nxt = {led_out[2:0], led_out[3]};
                default: led_nxt = {led_out[0], led_out[3:1]};
            endcase
        end
    end

    assign busy = (state == S_RUN);

endmodule

// File: tb/tb_led_arbiter_ctrl.sv
module tb_led_arbiter_ctrl;

    logic        clk_50M = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [5:0]  req_mode;
    logic [11:0] req_pat;
    logic [2:0]  grant;
    logic        busy;
    logic        tick;
    logic [3:0]  led_out;

    int vectors = 0;
    int miscompares = 0;

    led_arbiter_ctrl #(
        .CNT_MAX_TICK   (25'd4),
        .MIN_HOLD_TICKS (4'd2)
    ) dut (
        .clk_50M  (clk_50M),
        .rst_n    (rst_n),
        .req      (req),
        .req_mode (req_mode),
        .req_pat  (req_pat),
        .grant    (grant),
        .busy     (busy),
        .tick     (tick),
        .led_out  (led_out)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Advance to the next negedge at which tick is high (bounded).
    task automatic wait_tick();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_50M);
            seen = tick;
        end
        check("tick_seen", {3'b000, seen}, 4'b0001);
    endtask

    logic [3:0] rot_exp [4];

    initial begin
        rot_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst_n    = 1'b0;
        req      = 3'b000;
        req_mode = 6'b0;
        req_pat  = 12'b0;

        // Reset values.
        repeat (3) @(negedge clk_50M);
        check("rst_led",   led_out, 4'b1111);
        check("rst_grant", {1'b0, grant}, 4'b0000);
        check("rst_busy",  {3'b000, busy}, 4'b0000);
        check("rst_tick",  {3'b000, tick}, 4'b0000);

        // Release mid-cycle; that partial cycle is cycle 1, tick is high in cycle 6.
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_50M);
            check($sformatf("first_tick_c%0d", k + 1), {3'b000, tick}, (k == 5) ? 4'b0001 : 4'b0000);
        end

        // Rotate left from source 0.
        wait_tick();
        req = 3'b001; req_mode[1:0] = 2'b10; req_pat[3:0] = 4'b0001;
        @(negedge clk_50M);
        check("rotl_grant", {1'b0, grant}, 4'b0001);
        check("rotl_busy",  {3'b000, busy}, 4'b0001);
        check("rotl_load",  led_out, 4'b1110);
        for (int s = 0; s < 4; s++) begin
            wait_tick();
            check("rotl_pre_step", led_out, (s == 0) ? 4'b1110 : rot_exp[s - 1]);
            @(negedge clk_50M);
            check($sformatf("rotl_step%0d", s), led_out, rot_exp[s]);
        end
        req = 3'b000;
        @(negedge clk_50M);
        check("rotl_idle_led",  led_out, 4'b1111);
        check("rotl_idle_busy", {3'b000, busy}, 4'b0000);

        // Blink from source 1; later input changes must be ignored.
        wait_tick();
        req = 3'b010; req_mode[3:2] = 2'b01; req_pat[7:4] = 4'b1010;
        @(negedge clk_50M);
        check("blink_grant", {1'b0, grant}, 4'b0010);
        check("blink_load",  led_out, 4'b0101);
        req_pat[7:4] = 4'b1111; req_mode[3:2] = 2'b00;
        wait_tick();
        @(negedge clk_50M);
        check("blink_off", led_out, 4'b1111);
        wait_tick();
        @(negedge clk_50M);
        check("blink_on", led_out, 4'b0101);
        req = 3'b000;
        @(negedge clk_50M);
        check("blink_drop_led",   led_out, 4'b1111);
        check("blink_drop_grant", {1'b0, grant}, 4'b0000);
        check("blink_drop_busy",  {3'b000, busy}, 4'b0000);

        // Priority and release.
        req_mode = 6'b00_00_00; req_pat = {4'b1100, 4'b0000, 4'b0011};
        req = 3'b101;
        @(negedge clk_50M);
        check("prio_grant", {1'b0, grant}, 4'b0100);
        check("prio_led",   led_out, 4'b0011);
        req = 3'b001;
        @(negedge clk_50M);
        check("rel_grant", {1'b0, grant}, 4'b0001);
        check("rel_led",   led_out, 4'b1100);
        check("rel_busy",  {3'b000, busy}, 4'b0001);
        req = 3'b000;
        @(negedge clk_50M);
        check("rel_idle", {1'b0, grant}, 4'b0000);

        // Preemption: source 0 owns, source 2 waits.
        wait_tick();
        req_mode = 6'b00_00_00; req_pat = {4'b1000, 4'b0000, 4'b0001};
        req = 3'b001;
        @(negedge clk_50M);
        check("pre_grant0", {1'b0, grant}, 4'b0001);
        req = 3'b101;
        wait_tick();
        @(negedge clk_50M);
        check("pre_tick1", {1'b0, grant}, 4'b0001);
        wait_tick();
        @(negedge clk_50M);
        check("pre_tick2", {1'b0, grant}, 4'b0001);
        wait_tick();
        @(negedge clk_50M);
`ifdef LED_ARB_PREEMPT_EN
        check("pre_tick3_grant", {1'b0, grant}, 4'b0100);
        check("pre_tick3_led",   led_out, 4'b0111);
`else
        check("pre_tick3_grant", {1'b0, grant}, 4'b0001);
        check("pre_tick3_led",   led_out, 4'b1110);
`endif
        req = 3'b100;
        @(negedge clk_50M);
        check("pre_after_drop", {1'b0, grant}, 4'b0100);
        check("pre_after_led",  led_out, 4'b0111);
        req = 3'b000;
        @(negedge clk_50M);

        // Drop coincident with tick: no step, pending source 0 takes over.
        wait_tick();
        req_mode = 6'b00_10_00; req_pat = {4'b0000, 4'b0011, 4'b0100};
        req = 3'b011;
        @(negedge clk_50M);
        check("coin_grant1", {1'b0, grant}, 4'b0010);
        check("coin_led1",   led_out, 4'b1100);
        wait_tick();
        req = 3'b001;
        @(negedge clk_50M);
        check("coin_grant0", {1'b0, grant}, 4'b0001);
        check("coin_led0",   led_out, 4'b1011);
        check("coin_busy",   {3'b000, busy}, 4'b0001);
        req = 3'b000;
        @(negedge clk_50M);

        // Zero pattern stays dark under rotation.
        req_mode = 6'b11_00_00; req_pat = 12'h000;
        req = 3'b100;
        @(negedge clk_50M);
        check("zero_load", led_out, 4'b1111);
        wait_tick();
        @(negedge clk_50M);
        check("zero_step", led_out, 4'b1111);
        check("zero_busy", {3'b000, busy}, 4'b0001);
        req = 3'b000;
        @(negedge clk_50M);

        // Rotate right one step.
        req_mode = 6'b11_00_00; req_pat = {4'b0001, 8'h00};
        req = 3'b100;
        @(negedge clk_50M);
        check("rotr_load", led_out, 4'b1110);
        wait_tick();
        @(negedge clk_50M);
        check("rotr_step", led_out, 4'b0111);

        // Asynchronous reset while busy.
        #3 rst_n = 1'b0;
        #1;
        check("arst_grant", {1'b0, grant}, 4'b0000);
        check("arst_led",   led_out, 4'b1111);
        check("arst_busy",  {3'b000, busy}, 4'b0000);
        check("arst_tick",  {3'b000, tick}, 4'b0000);
        @(negedge clk_50M);
        rst_n = 1'b1;
        req = 3'b000;
        @(negedge clk_50M);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
